// File: rtl/button_event_pkg.sv
// button_event_pkg: shared definitions for button_event_ctrl and its FIFO.
// Contents:
//   evt_type_e   event codes presented on evt_type
//   btn_state_e  per-button FSM state encoding
//   btn_w()      width of a button index (at least one bit)
package button_event_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_REPEAT  = 2'b10
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_HELD   = 2'b01,
    ST_REPEAT = 2'b10
  } btn_state_e;

  function automatic int btn_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/event_fifo.sv
// event_fifo: synchronous show-ahead FIFO with full/empty flags.
// Ports:
//   clk, reset_n  clock, async active-low reset (pointers only)
//   push, wr_data write side; ignored while full
//   pop           read side; ignored while empty
//   rd_data       head entry, forced to zero while empty
//   full, empty   occupancy flags
module event_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Storage is not reset, so hide stale contents while empty.
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// button_event_ctrl: turns debounced button levels into press, release and
// auto-repeat events, arbitrated round-robin into one show-ahead event FIFO.
// Ports:
//   clk, reset_n         clock, async active-low reset
//   pbtn_db              debounced levels, 1 = pressed
//   repeat_en            per-button auto-repeat enable
//   evt_valid/evt_ready  head-of-queue handshake, pop on valid & ready
//   evt_btn, evt_type    head event: button index, 00 press/01 release/10 repeat
//   overflow             sticky: a press or release event was lost
//   clr_overflow         synchronous clear of overflow (set wins)
//
// Per-button FSM:
//   state     | meaning
//   ST_IDLE   | button released
//   ST_HELD   | pressed, counting ticks toward the first repeat
//   ST_REPEAT | auto-repeating, counting ticks toward the next repeat
module button_event_ctrl
  import button_event_pkg::*;
#(
  parameter int NUM_BUTTONS       = 6,
  parameter int CLK_FREQUENCY_HZ  = 50_000_000,
  parameter int TICK_HZ           = 1000,
  parameter int HOLD_TICKS        = 500,
  parameter int REPEAT_TICKS      = 100,
  parameter int FIFO_DEPTH        = 8,
  parameter int SIMULATE          = 0,
  parameter int SIMULATE_TICK_CNT = 5,
  localparam int BTN_W = btn_w(NUM_BUTTONS)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] pbtn_db,
  input  logic [NUM_BUTTONS-1:0] repeat_en,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [BTN_W-1:0]       evt_btn,
  output logic [1:0]             evt_type,
  output logic                   overflow,
  input  logic                   clr_overflow
);

  localparam int unsigned TICK_TOP = (SIMULATE != 0) ? SIMULATE_TICK_CNT
                                                     : (CLK_FREQUENCY_HZ / TICK_HZ) - 1;
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_TICKS - 1);
  localparam logic [15:0] REP_LAST  = 16'(REPEAT_TICKS - 1);
  localparam int FW = BTN_W + 2;

  // ---------------- timebase ----------------
  logic [31:0] div_cnt;
  logic        tick;

  assign tick = (div_cnt == TICK_TOP);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 32'd1;
    end
  end

  // ---------------- edge detect ----------------
  logic [NUM_BUTTONS-1:0] prev;
  logic [NUM_BUTTONS-1:0] rise;
  logic [NUM_BUTTONS-1:0] fall;

  assign rise = pbtn_db & ~prev;
  assign fall = ~pbtn_db & prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= '0;
    end else begin
      prev <= pbtn_db;
    end
  end

  // ---------------- per-button FSMs ----------------
  btn_state_e  st      [NUM_BUTTONS];
  btn_state_e  st_nxt  [NUM_BUTTONS];
  logic [15:0] cnt     [NUM_BUTTONS];
  logic [15:0] cnt_nxt [NUM_BUTTONS];

  logic [NUM_BUTTONS-1:0] set_press;
  logic [NUM_BUTTONS-1:0] set_release;
  logic [NUM_BUTTONS-1:0] set_repeat;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        st[i]  <= ST_IDLE;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        st[i]  <= st_nxt[i];
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      st_nxt[i]  = st[i];
      cnt_nxt[i] = cnt[i];
      case (st[i])
        ST_IDLE: begin
          if (rise[i]) begin
            st_nxt[i]  = ST_HELD;
            cnt_nxt[i] = '0;
          end
        end
        ST_HELD: begin
          if (fall[i]) begin
            st_nxt[i] = ST_IDLE;
          end else if (!repeat_en[i]) begin
            cnt_nxt[i] = '0;
          end else if (tick) begin
            if (cnt[i] == HOLD_LAST) begin
              st_nxt[i]  = ST_REPEAT;
              cnt_nxt[i] = '0;
            end else begin
              cnt_nxt[i] = cnt[i] + 16'd1;
            end
          end
        end
        ST_REPEAT: begin
          if (fall[i]) begin
            st_nxt[i] = ST_IDLE;
          end else if (!repeat_en[i]) begin
            st_nxt[i]  = ST_HELD;
            cnt_nxt[i] = '0;
          end else if (tick) begin
            if (cnt[i] == REP_LAST) begin
              cnt_nxt[i] = '0;
            end else begin
              cnt_nxt[i] = cnt[i] + 16'd1;
            end
          end
        end
        default: begin
          st_nxt[i]  = ST_IDLE;
          cnt_nxt[i] = '0;
        end
      endcase
    end
  end

  always_comb begin
    set_press   = '0;
    set_release = '0;
    set_repeat  = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      set_press[i]   = (st[i] == ST_IDLE) && rise[i];
      set_release[i] = (st[i] != ST_IDLE) && fall[i];
      set_repeat[i]  = !fall[i] && repeat_en[i] && tick &&
                       (((st[i] == ST_HELD)   && (cnt[i] == HOLD_LAST)) ||
                        ((st[i] == ST_REPEAT) && (cnt[i] == REP_LAST)));
    end
  end

  // ---------------- pending bits and arbiter ----------------
  logic [NUM_BUTTONS-1:0] pend_press;
  logic [NUM_BUTTONS-1:0] pend_release;
  logic [NUM_BUTTONS-1:0] pend_repeat;
  logic [NUM_BUTTONS-1:0] pend_any;
  logic [NUM_BUTTONS-1:0] grant_vec;
  logic [NUM_BUTTONS-1:0] clr_press;
  logic [NUM_BUTTONS-1:0] clr_release;
  logic [NUM_BUTTONS-1:0] clr_repeat;
  logic [BTN_W-1:0]       rr_ptr;
  logic                   grant;
  logic [BTN_W-1:0]       grant_idx;
  evt_type_e              grant_type;
  logic [BTN_W:0]         cand;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   ovf_set;
  logic [FW-1:0]          fifo_rd;

  assign pend_any = pend_press | pend_release | pend_repeat;

  // Search starts one past the last grant; cand stays below 2*NUM_BUTTONS,
  // so a single conditional subtract performs the wrap.
  always_comb begin
    grant     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!fifo_full) begin
      for (int k = 0; k < NUM_BUTTONS; k++) begin
        cand = {1'b0, rr_ptr} + (BTN_W + 1)'(k + 1);
        if (cand >= (BTN_W + 1)'(NUM_BUTTONS)) begin
          cand = cand - (BTN_W + 1)'(NUM_BUTTONS);
        end
        if (!grant && pend_any[cand[BTN_W-1:0]]) begin
          grant     = 1'b1;
          grant_idx = cand[BTN_W-1:0];
        end
      end
    end
  end

  // Within one button: press, then repeat, then release.
  always_comb begin
    grant_vec = '0;
    if (grant) begin
      grant_vec[grant_idx] = 1'b1;
    end
    if (pend_press[grant_idx]) begin
      grant_type = EVT_PRESS;
    end else if (pend_repeat[grant_idx]) begin
      grant_type = EVT_REPEAT;
    end else begin
      grant_type = EVT_RELEASE;
    end
    clr_press   = (grant_type == EVT_PRESS)   ? grant_vec : '0;
    clr_repeat  = (grant_type == EVT_REPEAT)  ? grant_vec : '0;
    clr_release = (grant_type == EVT_RELEASE) ? grant_vec : '0;
    // A bit being granted this cycle is free to take the new event.
    ovf_set = |((set_press & pend_press & ~clr_press) |
                (set_release & pend_release & ~clr_release));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_press   <= '0;
      pend_release <= '0;
      pend_repeat  <= '0;
      rr_ptr       <= BTN_W'(NUM_BUTTONS - 1);
      overflow     <= 1'b0;
    end else begin
      pend_press   <= (pend_press & ~clr_press) | set_press;
      pend_release <= (pend_release & ~clr_release) | set_release;
      pend_repeat  <= (pend_repeat & ~clr_repeat) | set_repeat;
      if (grant) begin
        rr_ptr <= grant_idx;
      end
      overflow <= ovf_set | (overflow & ~clr_overflow);
    end
  end

  // ---------------- event FIFO ----------------
  event_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (grant),
    .wr_data ({grant_idx, grant_type}),
    .pop     (evt_ready),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign evt_valid = !fifo_empty;
  assign evt_btn   = fifo_rd[FW-1:2];
  assign evt_type  = fifo_rd[1:0];

endmodule

// File: tb/tb_button_event_ctrl.sv
module tb_button_event_ctrl;

  localparam int N     = 6;
  localparam int DEPTH = 4;
  localparam int HOLD  = 3;
  localparam int REP   = 2;
  localparam int STC   = 3;
  localparam int P     = STC + 1;
  localparam int BW    = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  pbtn_db = '0;
  logic [N-1:0]  repeat_en = '0;
  logic          evt_ready = 1'b0;
  logic          clr_overflow = 1'b0;
  logic          evt_valid;
  logic [BW-1:0] evt_btn;
  logic [1:0]    evt_type;
  logic          overflow;

  int n_checks = 0;
  int n_fail   = 0;

  button_event_ctrl #(
    .NUM_BUTTONS       (N),
    .CLK_FREQUENCY_HZ  (50_000_000),
    .TICK_HZ           (1000),
    .HOLD_TICKS        (HOLD),
    .REPEAT_TICKS      (REP),
    .FIFO_DEPTH        (DEPTH),
    .SIMULATE          (1),
    .SIMULATE_TICK_CNT (STC)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pbtn_db      (pbtn_db),
    .repeat_en    (repeat_en),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_btn      (evt_btn),
    .evt_type     (evt_type),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Events: 0 press, 1 release, 2 repeat. Repeats are derived from the
  // number of ticks a button has been held with repeat enabled.
  typedef struct { int btn; int typ; } ev_t;
  ev_t exp_q[$];

  int m_edges;
  int m_cnt;
  int m_rr;
  bit m_ovf;
  bit m_prev  [N];
  int m_ticks [N];
  bit mp_press[N];
  bit mp_rel  [N];
  bit mp_rep  [N];

  task automatic model_reset();
    exp_q.delete();
    m_edges = 0;
    m_cnt   = 0;
    m_rr    = N - 1;
    m_ovf   = 1'b0;
    for (int i = 0; i < N; i++) begin
      m_prev[i] = 1'b0; m_ticks[i] = 0;
      mp_press[i] = 1'b0; mp_rel[i] = 1'b0; mp_rep[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    bit tick, full, pop, ovf_set, rise, fall;
    int g;
    tick    = ((m_edges % P) == P - 1);
    full    = (m_cnt == DEPTH);
    pop     = (m_cnt > 0) && evt_ready;
    ovf_set = 1'b0;
    g       = -1;
    if (!full) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_rr + k) % N;
        if (g < 0 && (mp_press[idx] || mp_rel[idx] || mp_rep[idx])) g = idx;
      end
    end
    if (g >= 0) begin
      ev_t e;
      e.btn = g;
      if (mp_press[g])    begin e.typ = 0; mp_press[g] = 1'b0; end
      else if (mp_rep[g]) begin e.typ = 2; mp_rep[g]   = 1'b0; end
      else                begin e.typ = 1; mp_rel[g]   = 1'b0; end
      exp_q.push_back(e);
      m_cnt++;
      m_rr = g;
    end
    for (int i = 0; i < N; i++) begin
      rise = pbtn_db[i] && !m_prev[i];
      fall = !pbtn_db[i] && m_prev[i];
      if (rise) begin
        if (mp_press[i]) ovf_set = 1'b1;
        mp_press[i] = 1'b1;
        m_ticks[i]  = 0;
      end else if (fall) begin
        if (mp_rel[i]) ovf_set = 1'b1;
        mp_rel[i] = 1'b1;
      end else if (pbtn_db[i]) begin
        if (!repeat_en[i]) begin
          m_ticks[i] = 0;
        end else if (tick) begin
          m_ticks[i]++;
          if (m_ticks[i] == HOLD ||
              (m_ticks[i] > HOLD && ((m_ticks[i] - HOLD) % REP) == 0))
            mp_rep[i] = 1'b1;
        end
      end
      m_prev[i] = pbtn_db[i];
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
    if (pop) m_cnt--;
    m_edges++;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      chk("evt_valid", evt_valid, (exp_q.size() > 0) ? 1 : 0);
      chk("overflow", overflow, m_ovf);
      if (exp_q.size() > 0 && evt_ready) begin
        ev_t e;
        e = exp_q.pop_front();
        chk("evt_btn", evt_btn, e.btn);
        chk("evt_type", evt_type, e.typ);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(3);
    chk("rst_evt_valid", evt_valid, 0);
    chk("rst_evt_btn", evt_btn, 0);
    chk("rst_evt_type", evt_type, 0);
    chk("rst_overflow", overflow, 0);
    reset_n = 1'b1;
    cyc(2);

    // Round-robin from reset pointer, then from pointer at 3.
    evt_ready = 1'b1;
    pbtn_db = 6'b101001;
    cyc(10);
    pbtn_db = '0;
    cyc(10);
    pbtn_db[3] = 1'b1; cyc(5);
    pbtn_db[3] = 1'b0; cyc(8);
    pbtn_db = 6'b101001;
    cyc(10);
    pbtn_db = '0;
    cyc(10);

    // Single press: evt_valid rises two clocks after the level change.
    pbtn_db[2] = 1'b1;
    cyc(1);
    chk("press_lat1", evt_valid, 0);
    cyc(1);
    chk("press_lat2", evt_valid, 1);
    cyc(18);
    pbtn_db[2] = 1'b0;
    cyc(10);

    // Auto-repeat on button 1.
    repeat_en[1] = 1'b1;
    pbtn_db[1] = 1'b1;
    cyc(12 * P);
    pbtn_db[1] = 1'b0;
    cyc(10);
    repeat_en = '0;

    // Backpressure: six presses into a four-deep FIFO.
    evt_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      pbtn_db[i] = 1'b1;
      cyc(1);
    end
    cyc(5);
    chk("bp_valid", evt_valid, 1);
    evt_ready = 1'b1;
    cyc(12);
    pbtn_db = '0;
    cyc(12);

    // Overflow with a full FIFO.
    evt_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pbtn_db[i] = 1'b1; cyc(2);
      pbtn_db[i] = 1'b0; cyc(2);
    end
    for (int r = 0; r < 2; r++) begin
      pbtn_db[4] = 1'b1; cyc(2);
      pbtn_db[4] = 1'b0; cyc(2);
    end
    chk("ovf_set", overflow, 1);
    clr_overflow = 1'b1; cyc(1);
    clr_overflow = 1'b0;
    chk("ovf_clear", overflow, 0);
    pbtn_db[4] = 1'b1; clr_overflow = 1'b1; cyc(1);
    clr_overflow = 1'b0;
    chk("ovf_set_beats_clr", overflow, 1);
    evt_ready = 1'b1;
    cyc(20);
    pbtn_db[4] = 1'b0;
    cyc(10);
    clr_overflow = 1'b1; cyc(1); clr_overflow = 1'b0;

    // Reset mid-stream with buttons held.
    evt_ready = 1'b0;
    pbtn_db = 6'b000111;
    cyc(6);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", evt_valid, 0);
    cyc(1);
    reset_n = 1'b1;
    cyc(3);
    evt_ready = 1'b1;
    cyc(10);
    pbtn_db = '0;
    cyc(10);

    // Randomized traffic.
    repeat_en = N'($urandom);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 15) == 0) pbtn_db[i] = ~pbtn_db[i];
      if ($urandom_range(0, 199) == 0) repeat_en = N'($urandom);
      evt_ready    = ((c / 200) % 3 == 2) ? ($urandom_range(0, 3) == 0)
                                          : ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 49) == 0);
      cyc(1);
    end

    evt_ready = 1'b1;
    clr_overflow = 1'b0;
    pbtn_db = '0;
    cyc(60);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_valid", evt_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
